// File: rtl/mdu_iter_core.sv
// Iterative multiply/divide unit: latency-padded multiply and a 32-step restoring divider.
// Optional macro MDU_DIV0_FAST_EN completes a divide by zero in one cycle.
module mdu_iter_core #(
  parameter int unsigned MUL_LAT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div0
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;   // partial remainder, or product high word
  logic [31:0] quo_q, quo_d;   // dividend shifting into quotient, or product low word
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        bzero_q, bzero_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        sgn;
  logic [63:0] ext_a, ext_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] shl;
  logic        sub_ok;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = 1'b0;

    sgn    = ~op[0];
    ext_a  = {{32{sgn & src_a[31]}}, src_a};
    ext_b  = {{32{sgn & src_b[31]}}, src_b};
    mag_a  = (sgn & src_a[31]) ? -src_a : src_a;
    mag_b  = (sgn & src_b[31]) ? -src_b : src_b;
    shl    = {rem_q, quo_q[31]};
    sub_ok = shl >= {1'b0, dvs_q};

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start) begin
            bzero_d = op[1] & (src_b == '0);
            if (!op[1]) begin
              state_d        = S_MUL;
              cnt_d          = 5'(MUL_LAT - 1);
              {rem_d, quo_d} = ext_a * ext_b;
            end else begin
              state_d = S_DIV;
              cnt_d   = 5'd31;
              rem_d   = '0;
              quo_d   = mag_a;
              dvs_d   = mag_b;
              qneg_d  = sgn & (src_a[31] ^ src_b[31]);
              rneg_d  = sgn & src_a[31];
`ifdef MDU_DIV0_FAST_EN
              if (src_b == '0) begin
                state_d = S_DONE;
                hi_d    = src_a;
                lo_d    = '1;
                div0_d  = 1'b1;
              end
`endif
            end
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
            hi_d    = rem_q;
            lo_d    = quo_q;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        S_DIV: begin
          rem_d = sub_ok ? 32'(shl - {1'b0, dvs_q}) : shl[31:0];
          quo_d = {quo_q[30:0], sub_ok};
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - 5'd1;
        end
        S_FIX: begin
          state_d = S_DONE;
          hi_d    = rneg_q ? -rem_q : rem_q;
          lo_d    = qneg_q ? -quo_q : quo_q;
          div0_d  = bzero_q;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign div0   = div0_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
